// File: rtl/itype_pkg.sv
// Shared definitions for the I-type sequencer: opcodes, ALU funct codes,
// FSM state encoding and instruction field positions.
package itype_pkg;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned RT_MSB  = 25;
  localparam int unsigned RT_LSB  = 21;
  localparam int unsigned RA_MSB  = 20;
  localparam int unsigned RA_LSB  = 16;
  localparam int unsigned IMM_MSB = 11;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [5:0] OP_ADDI   = 6'h0E;
  localparam logic [5:0] OP_SUBFIC = 6'h08;
  localparam logic [5:0] OP_ANDI   = 6'h1C;
  localparam logic [5:0] OP_ORI    = 6'h18;
  localparam logic [5:0] OP_XORI   = 6'h1A;
  localparam logic [5:0] OP_CMPI   = 6'h0B;

  // funct[5:4] = mode, funct[3:0] = operation
  localparam logic [5:0] FN_AND = 6'b000000;
  localparam logic [5:0] FN_OR  = 6'b000001;
  localparam logic [5:0] FN_ADD = 6'b000010;
  localparam logic [5:0] FN_XOR = 6'b000011;
  localparam logic [5:0] FN_SUB = 6'b000110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_RESP
  } state_t;

endpackage

// File: rtl/itype_decode.sv
// Combinational opcode lookup: ALU funct, writeback enable and illegal flag.
module itype_decode
  import itype_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [5:0] funct,
  output logic       writeback,
  output logic       illegal
);

  always_comb begin
    funct     = '0;
    writeback = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_ADDI:   begin funct = FN_ADD; writeback = 1'b1; end
      OP_SUBFIC: begin funct = FN_SUB; writeback = 1'b1; end
      OP_ANDI:   begin funct = FN_AND; writeback = 1'b1; end
      OP_ORI:    begin funct = FN_OR;  writeback = 1'b1; end
      OP_XORI:   begin funct = FN_XOR; writeback = 1'b1; end
      OP_CMPI:   funct = FN_SUB;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/itype_seq_ctrl.sv
// Multi-cycle I-type sequencer: accept, decode, execute with ALU settle
// wait states, optional register writeback, then hold a completion record.
module itype_seq_ctrl
  import itype_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  output logic [4:0]       dp_r1,
  output logic [4:0]       dp_r3,
  output logic [11:0]      dp_imm,
  output logic [5:0]       dp_funct,
  output logic             dp_we,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [31:0]      done_result,
  output logic             done_illegal,
  output logic             cr_zero,
  output logic             ov_sticky,
  output logic [CNT_W-1:0] retired_cnt
);

  state_t      state, state_nx;
  logic [5:0]  op_q;
  logic [4:0]  rt_q, ra_q;
  logic [11:0] imm_q;
  logic [3:0]  exec_cnt;
  logic [5:0]  dec_funct;
  logic        dec_wb, dec_ill;
  logic        accept, resp_hs, exec_last;
  logic        unused_rsvd;

  // Reserved field [15:12] is never latched.
  assign unused_rsvd = ^instr[15:12];

  itype_decode u_decode (
    .opcode    (op_q),
    .funct     (dec_funct),
    .writeback (dec_wb),
    .illegal   (dec_ill)
  );

  assign instr_ready = (state == ST_IDLE);
  assign done_valid  = (state == ST_RESP);
  assign dp_we       = (state == ST_WB);
  assign accept      = instr_valid && instr_ready;
  assign resp_hs     = done_valid && done_ready;
  assign exec_last   = (state == ST_EXEC) && (exec_cnt == '0);

  // Datapath controls are views of the latched fields, so they appear in
  // DECODE and hold until the next accept; reset clears them asynchronously.
  assign dp_r1    = ra_q;
  assign dp_r3    = rt_q;
  assign dp_imm   = imm_q;
  assign dp_funct = dec_ill ? '0 : dec_funct;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (accept) state_nx = ST_DECODE;
      ST_DECODE: state_nx = dec_ill ? ST_RESP : ST_EXEC;
      ST_EXEC:   if (exec_cnt == '0) state_nx = dec_wb ? ST_WB : ST_RESP;
      ST_WB:     state_nx = ST_RESP;
      ST_RESP:   if (done_ready) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= '0;
      rt_q         <= '0;
      ra_q         <= '0;
      imm_q        <= '0;
      exec_cnt     <= '0;
      done_result  <= '0;
      done_illegal <= 1'b0;
      cr_zero      <= 1'b0;
      ov_sticky    <= 1'b0;
      retired_cnt  <= '0;
    end else begin
      if (accept) begin
        op_q  <= instr[OPC_MSB:OPC_LSB];
        rt_q  <= instr[RT_MSB:RT_LSB];
        ra_q  <= instr[RA_MSB:RA_LSB];
        imm_q <= instr[IMM_MSB:IMM_LSB];
      end
      if (state == ST_DECODE) begin
        exec_cnt <= 4'(EXEC_CYCLES - 1);
        if (dec_ill) done_illegal <= 1'b1;
      end else if ((state == ST_EXEC) && (exec_cnt != '0)) begin
        exec_cnt <= exec_cnt - 4'd1;
      end
      // Flags are only trusted once the ALU has settled.
      if (exec_last) begin
        done_result <= alu_result;
        cr_zero     <= alu_zero;
        ov_sticky   <= ov_sticky | alu_overflow;
      end
      if (resp_hs) begin
        if (!done_illegal) retired_cnt <= retired_cnt + CNT_W'(1);
        done_illegal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_itype_seq_ctrl.sv
// Bench for itype_seq_ctrl: two instances (1 and 4 EXEC cycles) checked
// every cycle against a transaction-timeline model plus literal expectations.
module tb_itype_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid[2], done_ready[2], alu_zero[2], alu_overflow[2];
  logic [31:0] instr[2], alu_result[2];
  logic        instr_ready[2], dp_we[2], done_valid[2], done_illegal[2];
  logic        cr_zero[2], ov_sticky[2];
  logic [4:0]  dp_r1[2], dp_r3[2];
  logic [11:0] dp_imm[2];
  logic [5:0]  dp_funct[2];
  logic [31:0] done_result[2];
  logic [3:0]  ret0;
  logic [15:0] ret1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  itype_seq_ctrl #(.EXEC_CYCLES(1), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid[0]), .instr_ready(instr_ready[0]), .instr(instr[0]),
    .dp_r1(dp_r1[0]), .dp_r3(dp_r3[0]), .dp_imm(dp_imm[0]), .dp_funct(dp_funct[0]), .dp_we(dp_we[0]),
    .alu_result(alu_result[0]), .alu_zero(alu_zero[0]), .alu_overflow(alu_overflow[0]),
    .done_valid(done_valid[0]), .done_ready(done_ready[0]), .done_result(done_result[0]),
    .done_illegal(done_illegal[0]), .cr_zero(cr_zero[0]), .ov_sticky(ov_sticky[0]),
    .retired_cnt(ret0)
  );

  itype_seq_ctrl #(.EXEC_CYCLES(4), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid[1]), .instr_ready(instr_ready[1]), .instr(instr[1]),
    .dp_r1(dp_r1[1]), .dp_r3(dp_r3[1]), .dp_imm(dp_imm[1]), .dp_funct(dp_funct[1]), .dp_we(dp_we[1]),
    .alu_result(alu_result[1]), .alu_zero(alu_zero[1]), .alu_overflow(alu_overflow[1]),
    .done_valid(done_valid[1]), .done_ready(done_ready[1]), .done_result(done_result[1]),
    .done_illegal(done_illegal[1]), .cr_zero(cr_zero[1]), .ov_sticky(ov_sticky[1]),
    .retired_cnt(ret1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    total++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Opcode table as {legal, writeback, funct}.
  function automatic logic [7:0] optab(input logic [5:0] op);
    case (op)
      6'h0E:   return {2'b11, 6'b000010};
      6'h08:   return {2'b11, 6'b000110};
      6'h1C:   return {2'b11, 6'b000000};
      6'h18:   return {2'b11, 6'b000001};
      6'h1A:   return {2'b11, 6'b000011};
      6'h0B:   return {2'b10, 6'b000110};
      default: return 8'h00;
    endcase
  endfunction

  function automatic int ec(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Cycle (counted from accept = 0) at which done_valid first rises.
  function automatic int resp_k(input logic [7:0] t, input int e);
    if (!t[7]) return 2;
    return t[6] ? 3 + e : 2 + e;
  endfunction

  // Model: per instance, a busy flag and the cycle index since accept.
  bit          m_busy[2];
  int          m_k[2];
  logic [31:0] m_cur[2], m_res[2];
  logic        m_zero[2], m_ov[2], m_ill[2];
  int unsigned m_ret[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_busy[d] = 0; m_k[d] = 0; m_cur[d] = '0; m_res[d] = '0;
        m_zero[d] = 0; m_ov[d] = 0; m_ill[d] = 0; m_ret[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic [7:0] t;
        int e;
        t = optab(m_cur[d][31:26]);
        e = ec(d);
        if (!m_busy[d]) begin
          if (instr_valid[d]) begin
            m_busy[d] = 1; m_k[d] = 1; m_cur[d] = instr[d];
          end
        end else begin
          if (t[7] && m_k[d] == 1 + e) begin
            m_res[d]  = alu_result[d];
            m_zero[d] = alu_zero[d];
            m_ov[d]   = m_ov[d] | alu_overflow[d];
          end
          if (!t[7] && m_k[d] == 1) m_ill[d] = 1;
          if (m_k[d] >= resp_k(t, e) && done_ready[d]) begin
            m_busy[d] = 0;
            if (t[7]) m_ret[d]++;
            m_ill[d] = 0;
          end else begin
            m_k[d]++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        logic [7:0] t;
        int e;
        logic [31:0] r_act;
        t = optab(m_cur[d][31:26]);
        e = ec(d);
        r_act = (d == 0) ? {28'b0, ret0} : {16'b0, ret1};
        chk($sformatf("ready%0d", d), instr_ready[d], !m_busy[d]);
        chk($sformatf("we%0d", d), dp_we[d], m_busy[d] && t[7] && t[6] && m_k[d] == 2 + e);
        chk($sformatf("dv%0d", d), done_valid[d], m_busy[d] && m_k[d] >= resp_k(t, e));
        chk($sformatf("r1_%0d", d), dp_r1[d], m_cur[d][20:16]);
        chk($sformatf("r3_%0d", d), dp_r3[d], m_cur[d][25:21]);
        chk($sformatf("imm%0d", d), dp_imm[d], m_cur[d][11:0]);
        chk($sformatf("funct%0d", d), dp_funct[d], t[7] ? t[5:0] : 6'd0);
        chk($sformatf("result%0d", d), done_result[d], m_res[d]);
        chk($sformatf("illegal%0d", d), done_illegal[d], m_ill[d]);
        chk($sformatf("crzero%0d", d), cr_zero[d], m_zero[d]);
        chk($sformatf("ovst%0d", d), ov_sticky[d], m_ov[d]);
        chk($sformatf("retired%0d", d), r_act, m_ret[d] % ((d == 0) ? 16 : 65536));
      end
    end
  end

  // Offer one instruction and run it to completion. ALU result in cycle j
  // is base+j; overflow pulses only in cycle ovc; done_ready held low for
  // `hold` RESP cycles while a bogus instruction is offered.
  task automatic do_instr(input int d, input logic [31:0] w, input logic [31:0] base,
                          input logic z, input int ovc, input int hold,
                          output int we_first, output int we_cnt, output int dv_first,
                          output logic ill_seen);
    int n, j, h;
    bit fin;
    we_first = -1; we_cnt = 0; dv_first = -1; ill_seen = 1'b0; h = hold;
    @(negedge clk);
    instr_valid[d] = 1'b1; instr[d] = w; done_ready[d] = 1'b1;
    n = 0;
    while (!instr_ready[d] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      fail_now($sformatf("accept%0d", d));
      instr_valid[d] = 1'b0;
      return;
    end
    j = 0; fin = 0;
    while (!fin && j < 200) begin
      @(negedge clk); j++;
      instr_valid[d]  = 1'b0;
      alu_result[d]   = base + 32'(j);
      alu_zero[d]     = z;
      alu_overflow[d] = (j == ovc);
      if (dp_we[d]) begin
        if (we_first < 0) we_first = j;
        we_cnt++;
      end
      if (done_valid[d]) begin
        if (dv_first < 0) dv_first = j;
        ill_seen = ill_seen | done_illegal[d];
        if (h > 0) begin
          h--; done_ready[d] = 1'b0; instr_valid[d] = 1'b1; instr[d] = ~w;
        end else begin
          done_ready[d] = 1'b1;
        end
      end else if (dv_first >= 0) begin
        fin = 1;
      end else begin
        done_ready[d] = 1'b1;
      end
    end
    alu_overflow[d] = 1'b0;
    if (!fin) fail_now($sformatf("complete%0d", d));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wf, wc, df, n;
    logic il;
    logic [5:0] ops[4];
    ops = '{6'h08, 6'h1C, 6'h18, 6'h1A};
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      instr_valid[d] = 1'b0; done_ready[d] = 1'b0; alu_zero[d] = 1'b0;
      alu_overflow[d] = 1'b0; instr[d] = '0; alu_result[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", instr_ready[0], 1);
    chk("rst_retired", ret0, 0);
    chk("rst_funct", dp_funct[0], 0);
    chk("rst_dv", done_valid[0], 0);

    // ADDI rt=3 ra=5 imm=0x7FF, reserved bits non-zero
    do_instr(0, {6'h0E, 5'd3, 5'd5, 4'hA, 12'h7FF}, 32'h802, 1'b0, 0, 0, wf, wc, df, il);
    chk("addi_we_cycle", wf, 3);
    chk("addi_we_count", wc, 1);
    chk("addi_dv_cycle", df, 4);
    chk("addi_result", done_result[0], 32'h804);
    chk("addi_retired", ret0, 1);
    chk("addi_r1", dp_r1[0], 5);
    chk("addi_r3", dp_r3[0], 3);
    chk("addi_funct", dp_funct[0], 6'b000010);
    chk("addi_imm", dp_imm[0], 12'h7FF);

    // CMPI ra=4 imm=4, zero result
    do_instr(0, {6'h0B, 5'd9, 5'd4, 4'h0, 12'd4}, 32'h0, 1'b1, 0, 0, wf, wc, df, il);
    chk("cmpi_we_count", wc, 0);
    chk("cmpi_dv_cycle", df, 3);
    chk("cmpi_crzero", cr_zero[0], 1);
    chk("cmpi_retired", ret0, 2);

    // Illegal opcode 0x3F
    do_instr(0, {6'h3F, 5'd1, 5'd2, 4'h0, 12'h123}, 32'h55, 1'b0, 0, 0, wf, wc, df, il);
    chk("ill_we_count", wc, 0);
    chk("ill_dv_cycle", df, 2);
    chk("ill_flag", il, 1);
    chk("ill_retired", ret0, 2);
    chk("ill_funct", dp_funct[0], 0);

    // Back-pressure: done_ready low for 10 RESP cycles
    do_instr(0, {6'h0E, 5'd7, 5'd8, 4'h0, 12'h010}, 32'hDEAD0000, 1'b0, 0, 10, wf, wc, df, il);
    chk("hold_dv_cycle", df, 4);
    chk("hold_result", done_result[0], 32'hDEAD0002);
    chk("hold_retired", ret0, 3);

    // rt=0 is written; overflow in the last EXEC cycle is sticky
    do_instr(0, {6'h0E, 5'd0, 5'd1, 4'h0, 12'h001}, 32'h7FFFFFFD, 1'b0, 2, 0, wf, wc, df, il);
    chk("rt0_we_count", wc, 1);
    chk("rt0_r3", dp_r3[0], 0);
    chk("ov_set", ov_sticky[0], 1);

    // Fill the 4-bit counter to all-ones, then wrap
    for (int i = 0; i < 11; i++) begin
      do_instr(0, {ops[i % 4], 5'($urandom), 5'($urandom), 4'($urandom), 12'($urandom)},
               $urandom, 1'($urandom), 0, 0, wf, wc, df, il);
    end
    chk("cnt_allones", ret0, 15);
    do_instr(0, {6'h1A, 5'd4, 5'd6, 4'h0, 12'hABC}, 32'h1, 1'b0, 0, 0, wf, wc, df, il);
    chk("cnt_wrap", ret0, 0);
    chk("ov_still_set", ov_sticky[0], 1);

    // Four EXEC cycles: result from the last one, mid-EXEC overflow ignored
    do_instr(1, {6'h0E, 5'd2, 5'd6, 4'h0, 12'h055}, 32'h1000, 1'b0, 3, 0, wf, wc, df, il);
    chk("e4_result", done_result[1], 32'h1005);
    chk("e4_ov", ov_sticky[1], 0);
    chk("e4_we_cycle", wf, 6);
    chk("e4_dv_cycle", df, 7);
    chk("e4_retired", ret1, 1);

    // Reset asserted during WB
    @(negedge clk);
    instr_valid[0] = 1'b1; instr[0] = {6'h18, 5'd9, 5'd10, 4'h0, 12'h0F0}; done_ready[0] = 1'b0;
    n = 0;
    while (!instr_ready[0] && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    instr_valid[0] = 1'b0;
    n = 0;
    while (!dp_we[0] && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) fail_now("reach_wb");
    chk("pre_rst_we", dp_we[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_we_async", dp_we[0], 0);
    chk("rst_ready_async", instr_ready[0], 1);
    chk("rst_dv_async", done_valid[0], 0);
    chk("rst_r1_async", dp_r1[0], 0);
    chk("rst_ov_async", ov_sticky[0], 0);
    chk("rst_cnt_async", ret0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", instr_ready[0], 1);
    chk("post_rst_dv", done_valid[0], 0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/itype_seq_ctrl.md
Name: itype_seq_ctrl

Overview:
- Multi-cycle sequencer for the I-type register-file/ALU datapath.
- Accepts one 32-bit I-type instruction at a time over a valid/ready handshake and decodes opcode and fields.
- Drives the datapath controls: source/destination register indices, 12-bit immediate, 6-bit ALU funct and write-enable.
- Samples the ALU flags, then reports completion over a second valid/ready handshake with sticky status and a retired-instruction counter.

Parameters:
- EXEC_CYCLES, 1, ALU settle wait states in EXEC (legal range 1..15).
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk, in, 1, system clock, rising edge.
- rst_n, in, 1, reset, asynchronous, active-low.
- instr_valid, in, 1, instruction offered.
- instr_ready, out, 1, controller can accept; high only in IDLE.
- instr, in, 32, fields: [31:26] opcode, [25:21] rt (dest), [20:16] ra (src), [15:12] reserved, [11:0] imm.
- dp_r1, out, 5, source register index to datapath.
- dp_r3, out, 5, destination register index.
- dp_imm, out, 12, immediate.
- dp_funct, out, 6, ALU control: [3:0] operation, [5:4] mode.
- dp_we, out, 1, register-file write strobe, one cycle.
- alu_result, in, 32, ALU result from datapath.
- alu_zero, in, 1, ALU zero flag.
- alu_overflow, in, 1, ALU overflow flag.
- done_valid, out, 1, completion record valid.
- done_ready, in, 1, consumer accepts completion.
- done_result, out, 32, captured ALU result.
- done_illegal, out, 1, instruction was an illegal opcode.
- cr_zero, out, 1, zero flag of the last executed instruction.
- ov_sticky, out, 1, set on any overflow; cleared only by reset.
- retired_cnt, out, CNT_W, count of completed legal instructions; wraps.

Behaviour:
- Reset (async assert, sync release): state IDLE, instr_ready=1. All other outputs are 0: dp_*, dp_we, done_*, cr_zero, ov_sticky, retired_cnt.
- States: IDLE, DECODE, EXEC, WB, RESP.
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready, latch instr and go to DECODE.
- DECODE (1 cycle):
  - Look up the opcode. Drive dp_r1=ra, dp_r3=rt, dp_imm=imm, dp_funct from the table.
  - Illegal opcode: set done_illegal, force dp_funct=0, go to RESP (no EXEC, no WB).
  - Legal opcode: go to EXEC.
- EXEC:
  - Hold dp_* stable. A down-counter runs EXEC_CYCLES cycles.
  - In the last cycle, capture alu_result into done_result and alu_zero into cr_zero; OR alu_overflow into ov_sticky.
  - Then go to WB if the opcode writes back, otherwise RESP.
- WB:
  - dp_we=1 for exactly one cycle, dp_* unchanged; then RESP.
- RESP:
  - done_valid=1; the record is held stable until done_ready.
  - On handshake: retired_cnt increments if not illegal; clear done_illegal; go to IDLE.
- dp_* hold their last values outside DECODE..WB. dp_we=0 in every state except WB.
- Opcode table: opcode -> funct, writeback.
  - ADDI 0x0E -> 000010, wb
  - SUBFIC 0x08 -> 000110, wb
  - ANDI 0x1C -> 000000, wb
  - ORI 0x18 -> 000001, wb
  - XORI 0x1A -> 000011, wb
  - CMPI 0x0B -> 000110, no wb
  - All other opcodes are illegal.
- Latency, legal wb op, EXEC_CYCLES=1, accept at cycle 0: DECODE cycle 1, EXEC cycle 2, WB cycle 3, done_valid from cycle 4. Next instr_ready at cycle 5 at the earliest.
- Boundaries:
  - instr_valid is ignored outside IDLE.
  - done_ready is ignored when done_valid=0.
  - retired_cnt wraps from all-ones to 0.
  - rt=0 is written like any other register (no hardwired zero).
  - Reserved bits [15:12] are ignored.
  - Reset mid-operation aborts immediately: dp_we drops asynchronously, and no partial write or completion occurs.

Decomposition:
- Package itype_pkg holds: opcode localparams, funct encodings, state enum (3-bit), and instruction field position constants.
- One sub-module, itype_decode: combinational opcode -> {funct, writeback, illegal}. The FSM, counters and registers stay in the top.

Test Plan:
- ADDI rt=3 ra=5 imm=0x7FF, alu_result=0x804 → dp_r1=5, dp_r3=3, dp_funct=000010, dp_we high exactly at cycle 3; done_result=0x804; retired_cnt=1.
- CMPI ra=4 imm=4, alu_zero=1 → dp_we never asserts; cr_zero=1; done_valid at cycle 3; retired_cnt increments.
- Opcode 0x3F → done_illegal=1, no EXEC or WB cycles, done_valid at cycle 2; retired_cnt unchanged.
- Hold done_ready=0 for 10 cycles in RESP → done_* stable, instr_ready=0, a new instr_valid is ignored. Then release → IDLE.
- EXEC_CYCLES=4: alu_result changes in each EXEC cycle → done_result equals the value at the 4th EXEC cycle; alu_overflow pulsed in cycle 2 of EXEC only → ov_sticky stays 0 (sampled only in the last cycle).
- Assert rst_n=0 during WB → dp_we falls within the same cycle, all outputs return to reset values, instr_ready=1 after release.
